// File: rtl/mem_bank_cfg_writer_pkg.sv
// Shared types, defaults and helpers for the memory-bank config writer.
// Used by mem_bank_cfg_writer and its timer.
package mem_bank_cfg_pkg;

  localparam int BL_WIDTH_D     = 40;
  localparam int WL_WIDTH_D     = 4;
  localparam int WL_ADDR_W_D    = 2;
  localparam int SETUP_CYCLES_D = 1;
  localparam int PULSE_CYCLES_D = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Timer holds length-1, so clog2 of the longest phase suffices.
  function automatic int timer_w(input int s, input int p);
    int m;
    m = (s > p) ? s : p;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mem_bank_cfg_writer_if.sv
// Config word stream (valid/ready) into the bank writer.
// MEM_BANK_CFG_PARITY_EN adds an even-parity bit to each word.
interface mem_bank_cfg_writer_if
  import mem_bank_cfg_pkg::*;
#(
  parameter int BL_WIDTH  = BL_WIDTH_D,
  parameter int WL_ADDR_W = WL_ADDR_W_D
) ();

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [WL_ADDR_W-1:0] cfg_wl_addr;
  logic [BL_WIDTH-1:0]  cfg_bl_data;
  logic                 cfg_last;
`ifdef MEM_BANK_CFG_PARITY_EN
  logic                 cfg_parity;
`endif

  modport master (
    output cfg_valid,
    output cfg_wl_addr,
    output cfg_bl_data,
    output cfg_last,
`ifdef MEM_BANK_CFG_PARITY_EN
    output cfg_parity,
`endif
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_wl_addr,
    input  cfg_bl_data,
    input  cfg_last,
`ifdef MEM_BANK_CFG_PARITY_EN
    input  cfg_parity,
`endif
    output cfg_ready
  );

endinterface

// File: rtl/mem_bank_cfg_timer.sv
// Loadable down-counter with zero flag; stops at zero.
// Times the SETUP and PULSE phases of the bank writer.
module mem_bank_cfg_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_bank_cfg_writer.sv
// Memory-bank config writer: BL setup, one-hot WL pulse, hold.
// MEM_BANK_CFG_PARITY_EN enables even-parity checking of words.
module mem_bank_cfg_writer
  import mem_bank_cfg_pkg::*;
#(
  parameter int BL_WIDTH     = BL_WIDTH_D,
  parameter int WL_WIDTH     = WL_WIDTH_D,
  parameter int WL_ADDR_W    = WL_ADDR_W_D,
  parameter int SETUP_CYCLES = SETUP_CYCLES_D,
  parameter int PULSE_CYCLES = PULSE_CYCLES_D
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  mem_bank_cfg_writer_if.slave cfg,
  output logic [BL_WIDTH-1:0] bl_out,
  output logic [WL_WIDTH-1:0] wl_out,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int TW = timer_w(SETUP_CYCLES, PULSE_CYCLES);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);

  state_t               state;
  logic [WL_ADDR_W-1:0] addr_q;
  logic                 last_q;
  logic                 bad_q;
  logic                 accept;
  logic                 bad_in;
  logic                 t_load;
  logic [TW-1:0]        t_val;
  logic                 t_zero;

  assign accept        = (state == IDLE) && cfg.cfg_valid;
  assign cfg.cfg_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_comb begin
    bad_in = (int'(cfg.cfg_wl_addr) >= WL_WIDTH);
`ifdef MEM_BANK_CFG_PARITY_EN
    bad_in = bad_in |
      (^{cfg.cfg_wl_addr, cfg.cfg_bl_data, cfg.cfg_parity});
`endif
  end

  always_comb begin
    t_load = 1'b0;
    t_val  = SETUP_LD;
    if (accept) begin
      t_load = 1'b1;
      t_val  = SETUP_LD;
    end else if (state == SETUP && t_zero && !bad_q) begin
      t_load = 1'b1;
      t_val  = PULSE_LD;
    end
  end

  mem_bank_cfg_timer #(
    .W (TW)
  ) u_timer (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state  <= IDLE;
      bl_out <= '0;
      wl_out <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      addr_q <= '0;
      last_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            addr_q <= cfg.cfg_wl_addr;
            last_q <= cfg.cfg_last;
            bad_q  <= bad_in;
            bl_out <= cfg.cfg_bl_data;
            done   <= 1'b0;
            if (bad_in) err <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (t_zero) begin
            if (bad_q) begin
              state <= HOLD;
            end else begin
              wl_out <= WL_WIDTH'(1) << addr_q;
              state  <= PULSE;
            end
          end
        end
        PULSE: begin
          if (t_zero) begin
            wl_out <= '0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (last_q) done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bank_cfg_writer.sv
// Directed bench for mem_bank_cfg_writer (4-WL and 3-WL builds).
// Parity scenario runs when MEM_BANK_CFG_PARITY_EN is defined.
module tb_mem_bank_cfg_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_bank_cfg_writer_if #(.BL_WIDTH(40), .WL_ADDR_W(2)) if1 ();
  mem_bank_cfg_writer_if #(.BL_WIDTH(40), .WL_ADDR_W(2)) if2 ();

  logic [39:0] bl1, bl2;
  logic [3:0]  wl1;
  logic [2:0]  wl2;
  logic        busy1, done1, err1;
  logic        busy2, done2, err2;

  int checks = 0;
  int errors = 0;

  mem_bank_cfg_writer #(
    .BL_WIDTH(40), .WL_WIDTH(4), .WL_ADDR_W(2),
    .SETUP_CYCLES(1), .PULSE_CYCLES(2)
  ) dut1 (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg(if1),
    .bl_out(bl1), .wl_out(wl1),
    .busy(busy1), .done(done1), .err(err1)
  );

  mem_bank_cfg_writer #(
    .BL_WIDTH(40), .WL_WIDTH(3), .WL_ADDR_W(2),
    .SETUP_CYCLES(1), .PULSE_CYCLES(2)
  ) dut2 (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg(if2),
    .bl_out(bl2), .wl_out(wl2),
    .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put1(input logic v, input logic [1:0] a,
                      input logic [39:0] d, input logic l);
    if1.cfg_valid   = v;
    if1.cfg_wl_addr = a;
    if1.cfg_bl_data = d;
    if1.cfg_last    = l;
`ifdef MEM_BANK_CFG_PARITY_EN
    if1.cfg_parity  = ^{a, d};
`endif
  endtask

  task automatic put2(input logic v, input logic [1:0] a,
                      input logic [39:0] d, input logic l);
    if2.cfg_valid   = v;
    if2.cfg_wl_addr = a;
    if2.cfg_bl_data = d;
    if2.cfg_last    = l;
`ifdef MEM_BANK_CFG_PARITY_EN
    if2.cfg_parity  = ^{a, d};
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    put1(1'b0, 2'd0, 40'h0, 1'b0);
    put2(1'b0, 2'd0, 40'h0, 1'b0);
    step();
    step();
    checks++;
    if ({bl1, wl1, busy1, done1, err1, if1.cfg_ready} !==
        {40'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset1 got bl=%h wl=%b b/d/e/r=%b%b%b%b",
               bl1, wl1, busy1, done1, err1, if1.cfg_ready);
    end
    checks++;
    if ({bl2, wl2, busy2, done2, err2, if2.cfg_ready} !==
        {40'h0, 3'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset2 got bl=%h wl=%b b/d/e/r=%b%b%b%b",
               bl2, wl2, busy2, done2, err2, if2.cfg_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [3:0] ew;
    put1(1'b1, 2'd2, 40'hA5A5A5A5A5, 1'b1);
    step();
    put1(1'b0, 2'd0, 40'h0, 1'b0);
    checks++;
    if ({bl1, wl1, busy1, if1.cfg_ready} !==
        {40'hA5A5A5A5A5, 4'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_accept got bl=%h wl=%b busy=%b rdy=%b",
               bl1, wl1, busy1, if1.cfg_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      ew = (c <= 2) ? 4'b0100 : 4'b0000;
      checks++;
      if ({wl1, if1.cfg_ready, done1, err1} !==
          {ew, c == 4, c == 4, 1'b0}) begin
        errors++;
        $display("FAIL single_c%0d got wl=%b r/d/e=%b%b%b want wl=%b",
                 c, wl1, if1.cfg_ready, done1, err1, ew);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] d [4];
    logic [3:0]  ew;
    d[0] = 40'h1111111111;
    d[1] = 40'h2222222222;
    d[2] = 40'h3333333333;
    d[3] = 40'h4444444444;
    put1(1'b1, 2'd0, d[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) put1(1'b1, 2'(k + 1), d[k + 1], k == 2);
      else       put1(1'b0, 2'd0, 40'h0, 1'b0);
      checks++;
      if ({bl1, wl1, if1.cfg_ready, busy1} !==
          {d[k], 4'h0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL b2b_accept%0d got bl=%h wl=%b rdy=%b",
                 k, bl1, wl1, if1.cfg_ready);
      end
      for (int c = 1; c <= 4; c++) begin
        step();
        ew = (c <= 2) ? (4'b0001 << k) : 4'b0000;
        checks++;
        if ({bl1, wl1, if1.cfg_ready, done1} !==
            {d[k], ew, c == 4, (c == 4) && (k == 3)}) begin
          errors++;
          $display("FAIL b2b_w%0d_c%0d got bl=%h wl=%b r/d=%b%b want wl=%b",
                   k, c, bl1, wl1, if1.cfg_ready, done1, ew);
        end
      end
    end
  endtask

  task automatic test_valid_toggle();
    logic [3:0] ew;
    put1(1'b1, 2'd1, 40'h0F0F0F0F0F, 1'b0);
    step();
    for (int c = 1; c <= 4; c++) begin
      put1(c[0], 2'(c), {8'(c), 32'($urandom)}, 1'b1);
      if (c == 4) put1(1'b0, 2'd3, 40'hFFFFFFFFFF, 1'b1);
      step();
      ew = (c <= 2) ? 4'b0010 : 4'b0000;
      checks++;
      if ({bl1, wl1, if1.cfg_ready} !==
          {40'h0F0F0F0F0F, ew, c == 4}) begin
        errors++;
        $display("FAIL toggle_c%0d got bl=%h wl=%b rdy=%b want wl=%b",
                 c, bl1, wl1, if1.cfg_ready, ew);
      end
    end
    step();
    checks++;
    if ({bl1, busy1, done1, wl1} !==
        {40'h0F0F0F0F0F, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL toggle_idle got bl=%h busy=%b done=%b wl=%b",
               bl1, busy1, done1, wl1);
    end
  endtask

  task automatic test_reset_mid_pulse();
    put1(1'b1, 2'd1, 40'h123456789A, 1'b1);
    step();
    put1(1'b0, 2'd0, 40'h0, 1'b0);
    step();
    checks++;
    if (wl1 !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_pulse got wl=%b want 0010", wl1);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({bl1, wl1, busy1, done1, err1} !==
        {40'h0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_clear got bl=%h wl=%b b/d/e=%b%b%b",
               bl1, wl1, busy1, done1, err1);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({if1.cfg_ready, busy1, wl1} !== {1'b1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL midrst_ready got rdy=%b busy=%b wl=%b",
               if1.cfg_ready, busy1, wl1);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] ew;
    put2(1'b1, 2'd3, 40'hDEADBEEF01, 1'b1);
    step();
    put2(1'b0, 2'd0, 40'h0, 1'b0);
    checks++;
    if ({err2, wl2, if2.cfg_ready, busy2} !==
        {1'b1, 3'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL oor_accept got err=%b wl=%b rdy=%b busy=%b",
               err2, wl2, if2.cfg_ready, busy2);
    end
    step();
    checks++;
    if ({wl2, if2.cfg_ready, busy2, done2} !==
        {3'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL oor_hold got wl=%b rdy=%b busy=%b done=%b",
               wl2, if2.cfg_ready, busy2, done2);
    end
    step();
    checks++;
    if ({wl2, if2.cfg_ready, busy2, done2, err2} !==
        {3'h0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL oor_idle got wl=%b r/b/d/e=%b%b%b%b",
               wl2, if2.cfg_ready, busy2, done2, err2);
    end
    put2(1'b1, 2'd1, 40'hCAFE000001, 1'b0);
    step();
    put2(1'b0, 2'd0, 40'h0, 1'b0);
    checks++;
    if ({bl2, done2, err2, wl2} !==
        {40'hCAFE000001, 1'b0, 1'b1, 3'h0}) begin
      errors++;
      $display("FAIL oor_next_accept got bl=%h done=%b err=%b wl=%b",
               bl2, done2, err2, wl2);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      ew = (c <= 2) ? 3'b010 : 3'b000;
      checks++;
      if ({wl2, if2.cfg_ready, err2} !== {ew, c == 4, 1'b1}) begin
        errors++;
        $display("FAIL oor_next_c%0d got wl=%b rdy=%b err=%b want wl=%b",
                 c, wl2, if2.cfg_ready, err2, ew);
      end
    end
  endtask

`ifdef MEM_BANK_CFG_PARITY_EN
  task automatic test_parity();
    logic [3:0] ew;
    put1(1'b1, 2'd2, 40'h0123456789, 1'b0);
    if1.cfg_parity = ~if1.cfg_parity;
    step();
    put1(1'b0, 2'd0, 40'h0, 1'b0);
    checks++;
    if ({err1, wl1, busy1} !== {1'b1, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL par_bad got err=%b wl=%b busy=%b", err1, wl1, busy1);
    end
    step();
    step();
    checks++;
    if ({wl1, if1.cfg_ready, err1} !== {4'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL par_bad_end got wl=%b rdy=%b err=%b",
               wl1, if1.cfg_ready, err1);
    end
    put1(1'b1, 2'd3, 40'h0123456789, 1'b0);
    step();
    put1(1'b0, 2'd0, 40'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step();
      ew = (c <= 2) ? 4'b1000 : 4'b0000;
      checks++;
      if ({wl1, if1.cfg_ready} !== {ew, c == 4}) begin
        errors++;
        $display("FAIL par_good_c%0d got wl=%b rdy=%b want wl=%b",
                 c, wl1, if1.cfg_ready, ew);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_toggle();
    test_reset_mid_pulse();
    test_out_of_range();
`ifdef MEM_BANK_CFG_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
